// File: rtl/axilite_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : axilite_pkg                                            |
// | Description : Shared AXI4-Lite types and constants for the register  |
// |               file responder.                                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package axilite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage
`default_nettype wire

// File: rtl/axilite_regbank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : axilite_regbank                                        |
// | Description : Word register array with one synchronous write port,   |
// |               one combinational read port and range flags.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module axilite_regbank
  import axilite_pkg::*;
#(
  parameter int DATA_W   = AXI_DATA_W,
  parameter int NUM_REGS = 64,
  parameter int IDX_W    = AXI_ADDR_W - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  output logic              w_in_range,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata,
  output logic              in_range,
  output logic [DATA_W-1:0] reg0,
  output logic [DATA_W-1:0] reg1
);

  localparam logic [IDX_W-1:0] LIMIT = IDX_W'(NUM_REGS);
  localparam int               SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_W-1:0] regs [NUM_REGS];

  assign w_in_range = (widx < LIMIT);
  assign in_range   = (ridx < LIMIT);

  // Out-of-range writes are dropped here, so the caller only has to report them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && w_in_range) begin
      regs[widx[SEL_W-1:0]] <= wdata;
    end
  end

  // Out-of-range reads return zero rather than an aliased register
  assign rdata = in_range ? regs[ridx[SEL_W-1:0]] : '0;
  assign reg0  = regs[0];
  assign reg1  = regs[1];

endmodule
`default_nettype wire

// File: rtl/axilite_regfile_s.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : axilite_regfile_s                                      |
// | Description : AXI4-Lite responder over a bank of 32-bit registers,   |
// |               registers 0 and 1 exported as live control words.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module axilite_regfile_s
  import axilite_pkg::*;
#(
  parameter int ADDR_W   = AXI_ADDR_W,
  parameter int DATA_W   = AXI_DATA_W,
  parameter int NUM_REGS = 64
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [1:0]        s_axi_bresp,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic [DATA_W-1:0] ctrl0,
  output logic [DATA_W-1:0] ctrl1
);

  localparam int IDX_W = ADDR_W - 2;

  w_state_t          w_state, w_state_nx;
  r_state_t          r_state, r_state_nx;
  logic              alive;
  logic              aw_held, w_held;
  logic [IDX_W-1:0]  aw_idx;
  logic [DATA_W-1:0] w_data;
  logic              commit;
  logic              w_in_range, r_in_range;
  logic [DATA_W-1:0] rd_word;
  logic              unused_addr_lsbs;

  // Byte lanes within a word are not decoded
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  axilite_regbank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk        (s_axi_aclk),
    .rst_n      (s_axi_aresetn),
    .we         (commit),
    .widx       (aw_idx),
    .wdata      (w_data),
    .w_in_range (w_in_range),
    .ridx       (s_axi_araddr[ADDR_W-1:2]),
    .rdata      (rd_word),
    .in_range   (r_in_range),
    .reg0       (ctrl0),
    .reg1       (ctrl1)
  );

  // Keeps every ready low while reset is held and for the first cycle after release
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) alive <= 1'b0;
    else                alive <= 1'b1;
  end

  // Write FSM state register
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) w_state <= W_IDLE;
    else                w_state <= w_state_nx;
  end

  // Write next-state and ready generation; commit once both halves are held
  always_comb begin
    w_state_nx    = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    commit        = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = alive && !aw_held;
        s_axi_wready  = alive && !w_held;
        if (aw_held && w_held) begin
          commit     = 1'b1;
          w_state_nx = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bvalid && s_axi_bready) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  // Write datapath: AW/W holding latches and the B channel
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else if (commit) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi_awaddr[ADDR_W-1:2];
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
      end
      if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
    end
  end

  // Read FSM state register
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) r_state <= R_IDLE;
    else                r_state <= r_state_nx;
  end

  // Read next-state and arready generation
  always_comb begin
    r_state_nx    = r_state;
    s_axi_arready = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = alive;
        if (s_axi_arvalid && alive) r_state_nx = R_DATA;
      end
      R_DATA: begin
        if (s_axi_rready) r_state_nx = R_IDLE;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  // Read datapath: capture on AR handshake (pre-write value), hold until accepted
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (s_axi_arvalid && s_axi_arready) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_word;
      s_axi_rresp  <= r_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axilite_regfile_s.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_axilite_regfile_s                                   |
// | Description : Scoreboard bench for axilite_regfile_s with an array   |
// |               reference model and randomized traffic.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_axilite_regfile_s;

  localparam int NREG = 64;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata, ctrl0, ctrl1;
  logic [1:0]  bresp, rresp;

  logic [31:0] model [NREG];
  logic [1:0]  exp_b [$];
  rexp_t       exp_r [$];
  int          compared   = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  axilite_regfile_s #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(NREG)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_awaddr  (awaddr),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_wdata   (wdata),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_bresp   (bresp),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_araddr  (araddr),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .ctrl0         (ctrl0),
    .ctrl1         (ctrl1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got timeout expected handshake at %0t", name, $time);
  endtask

  // Reference: a word index below NREG is a live register, anything else is an error
  function automatic bit in_rng(input logic [31:0] addr);
    return (addr >> 2) < NREG;
  endfunction

  function automatic rexp_t model_read(input logic [31:0] addr);
    rexp_t e;
    if (in_rng(addr)) begin e.data = model[addr >> 2]; e.resp = 2'b00; end
    else              begin e.data = 32'h0;            e.resp = 2'b10; end
    return e;
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data);
    if (in_rng(addr)) begin model[addr >> 2] = data; return 2'b00; end
    return 2'b10;
  endfunction

  // Scoreboard monitor: every B/R handshake consumes the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (exp_b.size() == 0) fail_now("b_unexpected");
      else check("bresp", 32'(bresp), 32'(exp_b.pop_front()));
    end
    if (rst_n && rvalid && rready) begin
      if (exp_r.size() == 0) fail_now("r_unexpected");
      else begin
        rexp_t e;
        e = exp_r.pop_front();
        check("rdata", rdata, e.data);
        check("rresp", 32'(rresp), 32'(e.resp));
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done, w_done, got_b;
    int lat;
    logic [1:0] want;
    want = model_write(addr, data);
    exp_b.push_back(want);
    aw_done = 0; w_done = 0;
    for (int cyc = 0; cyc < 100 && !(aw_done && w_done); cyc++) begin
      awvalid = !aw_done && (cyc >= aw_dly); awaddr = addr;
      wvalid  = !w_done  && (cyc >= w_dly);  wdata  = data;
      @(negedge clk);
      check("bvalid_before_commit", 32'(bvalid), 32'd0);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready)   w_done  = 1;
      @(posedge clk); #1;
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) fail_now("write_addr_data");
    got_b = 0; lat = 0;
    for (int c = 0; c < 50 && !got_b; c++) begin
      @(negedge clk);
      if (bvalid) got_b = 1;
      else begin lat++; @(posedge clk); #1; end
    end
    if (!got_b) fail_now("bvalid_wait");
    check("b_latency", 32'(lat), 32'd1);
    for (int k = 0; k < b_dly; k++) begin
      check("bvalid_held", 32'(bvalid), 32'd1);
      check("bresp_held", 32'(bresp), 32'(want));
      check("awready_in_resp", 32'(awready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1; bready = 1;
    @(negedge clk);
    @(posedge clk); #1; bready = 0;
    @(negedge clk);
    check("bvalid_drop", 32'(bvalid), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
    rexp_t e;
    bit done;
    e = model_read(addr);
    exp_r.push_back(e);
    repeat (ar_dly) begin @(posedge clk); #1; end
    arvalid = 1; araddr = addr;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (arready) done = 1;
      @(posedge clk); #1;
    end
    arvalid = 0;
    if (!done) fail_now("ar_wait");
    @(negedge clk);
    check("rvalid_latency", 32'(rvalid), 32'd1);
    for (int k = 0; k < r_dly; k++) begin
      check("rdata_held", rdata, e.data);
      check("rresp_held", 32'(rresp), 32'(e.resp));
      check("arready_in_data", 32'(arready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1; rready = 1;
    @(negedge clk);
    @(posedge clk); #1; rready = 0;
    @(negedge clk);
    check("rvalid_drop", 32'(rvalid), 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return $urandom();
    return 32'($urandom_range(0, 32'h11F));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] bw;
    rst_n = 0; awvalid = 0; wvalid = 0; arvalid = 1; bready = 0; rready = 0;
    awaddr = 0; wdata = 0; araddr = 32'h87;
    for (int i = 0; i < NREG; i++) model[i] = 32'h0;

    // Reset with a read request pending
    repeat (4) begin
      @(negedge clk);
      check("rst_awready", 32'(awready), 32'd0);
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_bvalid",  32'(bvalid),  32'd0);
      check("rst_rvalid",  32'(rvalid),  32'd0);
      check("rst_ctrl0",   ctrl0,        32'd0);
      check("rst_rdata",   rdata,        32'd0);
      @(posedge clk); #1;
    end
    arvalid = 0; rst_n = 1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_rvalid", 32'(rvalid), 32'd0);
      @(posedge clk); #1;
    end

    // Basic write and read back
    do_write(32'h87, 32'h12345678, 0, 0, 0);
    do_read (32'h87, 0, 0);
    // W leads AW by three cycles, B held off for five
    do_write(32'h0F, 32'hC0DE1234, 3, 0, 5);
    do_read (32'h0C, 0, 0);
    // Out of range, then confirm no aliasing into word 0
    do_write(32'h100, 32'hDEADBEEF, 0, 0, 0);
    do_read (32'h100, 0, 0);
    do_read (32'h00, 0, 0);

    // Read of register 0 in the cycle its write commits sees the old value
    exp_r.push_back(model_read(32'h0));
    bw = model_write(32'h0, 32'hA5A5A5A5);
    exp_b.push_back(bw);
    awvalid = 1; awaddr = 0; wvalid = 1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    check("same_aw_w_ready", 32'({awready, wready}), 32'd3);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 1; araddr = 0;
    @(negedge clk);
    check("same_arready", 32'(arready), 32'd1);
    check("same_ctrl0_old", ctrl0, 32'h0);
    @(posedge clk); #1;
    arvalid = 0; bready = 1; rready = 1;
    @(negedge clk);
    check("same_ctrl0_new", ctrl0, 32'hA5A5A5A5);
    check("same_bvalid", 32'(bvalid), 32'd1);
    check("same_rvalid", 32'(rvalid), 32'd1);
    @(posedge clk); #1;
    bready = 0; rready = 0;
    @(posedge clk); #1;
    do_read(32'h00, 0, 0);
    // Read backpressure
    do_read(32'h87, 0, 4);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(rand_addr(), $urandom(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(rand_addr(), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    @(negedge clk);
    check("final_ctrl0", ctrl0, model[0]);
    check("final_ctrl1", ctrl1, model[1]);
    repeat (5) @(posedge clk);
    check("exp_b_left", 32'(exp_b.size()), 32'd0);
    check("exp_r_left", 32'(exp_r.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
